// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: FSM state codes,
// grant-side encoding and the fixed attributes of an instruction refill.
package mem_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_side_e;

    localparam int         STARVE_W    = 4;
    localparam logic [1:0] MEM_SIZE_W  = 2'b10;
    localparam logic [3:0] MEM_SEL_ALL = 4'b1111;

endpackage

// File: rtl/mem_req_arbiter_pick.sv
// Combinational winner select between the I and D requesters.
// Ports:
//   i_req, d_req  - qualified requests (already gated by IDLE / flush)
//   last_grant    - side that won the previous grant
//   starve_cnt    - consecutive D grants made while I was waiting
//   gnt_i, gnt_d  - one-hot (or zero) grant
module mem_req_arbiter_pick
    import mem_req_arbiter_pkg::*;
#(
    parameter int ARB_RR       = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                i_req,
    input  logic                d_req,
    input  gnt_side_e           last_grant,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                gnt_i,
    output logic                gnt_d
);

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (i_req && d_req) begin
            if (ARB_RR != 0) begin
                // Tie: hand the port to whoever did not win last time.
                if (last_grant == GNT_D) gnt_i = 1'b1;
                else                     gnt_d = 1'b1;
            end else begin
                // Data normally wins; I gets one turn once it has waited long enough.
                if (starve_cnt >= STARVE_W'(STARVE_LIMIT)) gnt_i = 1'b1;
                else                                       gnt_d = 1'b1;
            end
        end else begin
            gnt_i = i_req;
            gnt_d = d_req;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the I-cache refill port and the D-cache/uncached port onto the
// single SRAM-like port of axi_interface. The winning request is latched on
// the grant edge and held until mem_ready; ready is routed to the owner only.
// A data transaction is abandoned on an exception flush.
// Ports:
//   clk, resetn                 - clock, async active-low reset
//   i_req/i_addr/i_ready        - instruction refill requester
//   d_req/d_wr/d_size/d_sel/
//   d_addr/d_wdata/d_ready      - data requester
//   flush                       - exception flush
//   mem_*                       - latched request towards axi_interface
//   mem_ready                   - transaction done pulse from axi_interface
//   mem_flush                   - flush forwarded while a data access is owned
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int ARB_RR       = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    input  logic        flush,
    output logic [31:0] mem_a,
    output logic        mem_access,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_st_data,
    input  logic        mem_ready,
    output logic        mem_flush
);

    arb_state_e          state_q, state_d;
    gnt_side_e           last_grant;
    logic [STARVE_W-1:0] starve_cnt;
    logic                idle, gnt_i, gnt_d;

    assign idle = (state_q == ARB_IDLE);

    // A flush in IDLE must not let a doomed data access start; I may still go.
    mem_req_arbiter_pick #(
        .ARB_RR      (ARB_RR),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .i_req     (idle && i_req),
        .d_req     (idle && d_req && !flush),
        .last_grant(last_grant),
        .starve_cnt(starve_cnt),
        .gnt_i     (gnt_i),
        .gnt_d     (gnt_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_i)      state_d = ARB_BUSY_I;
                else if (gnt_d) state_d = ARB_BUSY_D;
            end
            ARB_BUSY_I: if (mem_ready)          state_d = ARB_IDLE;
            ARB_BUSY_D: if (mem_ready || flush) state_d = ARB_IDLE;
            default:                            state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ARB_IDLE;
            last_grant  <= GNT_D;
            starve_cnt  <= '0;
            mem_a       <= '0;
            mem_write   <= 1'b0;
            mem_size    <= '0;
            mem_sel     <= '0;
            mem_st_data <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_i) begin
                mem_a       <= i_addr;
                mem_write   <= 1'b0;
                mem_size    <= MEM_SIZE_W;
                mem_sel     <= MEM_SEL_ALL;
                mem_st_data <= '0;
                last_grant  <= GNT_I;
                starve_cnt  <= '0;
            end else if (gnt_d) begin
                mem_a       <= d_addr;
                mem_write   <= d_wr;
                mem_size    <= d_size;
                mem_sel     <= d_sel;
                mem_st_data <= d_wdata;
                last_grant  <= GNT_D;
                // Only count grants that actually made I wait; saturate.
                if (i_req && starve_cnt != '1) starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Derived from registered state so reset clears them immediately.
    assign mem_access = !idle;
    assign i_ready    = (state_q == ARB_BUSY_I) && mem_ready;
    assign d_ready    = (state_q == ARB_BUSY_D) && mem_ready && !flush;
    assign mem_flush  = (state_q == ARB_BUSY_D) && flush;

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, d_req, d_wr, flush, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;

    // dut0: fixed priority + starvation guard; dut1: round-robin. Shared stimulus.
    logic        i_ready0, d_ready0, mem_access0, mem_write0, mem_flush0;
    logic        i_ready1, d_ready1, mem_access1, mem_write1, mem_flush1;
    logic [31:0] mem_a0, mem_st_data0, mem_a1, mem_st_data1;
    logic [1:0]  mem_size0, mem_size1;
    logic [3:0]  mem_sel0, mem_sel1;

    always #5 clk = ~clk;

    mem_req_arbiter #(.ARB_RR(0), .STARVE_LIMIT(4)) dut0 (
        .clk(clk), .resetn(resetn), .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready0),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_sel(d_sel), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(d_ready0), .flush(flush), .mem_a(mem_a0),
        .mem_access(mem_access0), .mem_write(mem_write0), .mem_size(mem_size0),
        .mem_sel(mem_sel0), .mem_st_data(mem_st_data0), .mem_ready(mem_ready),
        .mem_flush(mem_flush0)
    );

    mem_req_arbiter #(.ARB_RR(1), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .resetn(resetn), .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready1),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_sel(d_sel), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(d_ready1), .flush(flush), .mem_a(mem_a1),
        .mem_access(mem_access1), .mem_write(mem_write1), .mem_size(mem_size1),
        .mem_sel(mem_sel1), .mem_st_data(mem_st_data1), .mem_ready(mem_ready),
        .mem_flush(mem_flush1)
    );

    // Observed view of whichever instance is under test.
    bit          sel_rr = 1'b0;
    logic        mx_access, mx_i_ready, mx_d_ready, mx_write, mx_flush;
    logic [31:0] mx_a, mx_st_data;
    logic [1:0]  mx_size;
    logic [3:0]  mx_sel;

    assign mx_access  = sel_rr ? mem_access1  : mem_access0;
    assign mx_i_ready = sel_rr ? i_ready1     : i_ready0;
    assign mx_d_ready = sel_rr ? d_ready1     : d_ready0;
    assign mx_write   = sel_rr ? mem_write1   : mem_write0;
    assign mx_flush   = sel_rr ? mem_flush1   : mem_flush0;
    assign mx_a       = sel_rr ? mem_a1       : mem_a0;
    assign mx_st_data = sel_rr ? mem_st_data1 : mem_st_data0;
    assign mx_size    = sel_rr ? mem_size1    : mem_size0;
    assign mx_sel     = sel_rr ? mem_sel1     : mem_sel0;

    typedef struct packed {
        logic        is_d;
        logic [31:0] a;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_i();
        exp_q.push_back('{is_d: 1'b0, a: i_addr, wr: 1'b0, size: 2'b10, sel: 4'hF, wdata: 32'h0});
    endtask

    task automatic push_d();
        exp_q.push_back('{is_d: 1'b1, a: d_addr, wr: d_wr, size: d_size, sel: d_sel, wdata: d_wdata});
    endtask

    // Wait (bounded) for a grant, pop the scoreboard and check the latched fields.
    task automatic wait_grant(output exp_t e);
        int k = 0;
        while (!mx_access && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("grant_seen", 32'(mx_access), 32'd1);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk(e.is_d ? "d_mem_a" : "i_mem_a", mx_a, e.a);
        chk("mem_write", 32'(mx_write), 32'(e.wr));
        chk("mem_size", 32'(mx_size), 32'(e.size));
        chk("mem_sel", 32'(mx_sel), 32'(e.sel));
        chk("mem_st_data", mx_st_data, e.wdata);
    endtask

    // Hold the transaction lat cycles after grant, pulse mem_ready, check routing,
    // then drop strobes (unless kept as a back-to-back request) and check the bubble.
    task automatic complete(input exp_t e, input int lat, input bit keep_d, input bit keep_i);
        repeat (lat - 1) @(negedge clk);
        chk("held_access", 32'(mx_access), 32'd1);
        chk("held_addr", mx_a, e.a);
        mem_ready = 1'b1;
        #1;
        chk("i_ready", 32'(mx_i_ready), 32'(!e.is_d));
        chk("d_ready", 32'(mx_d_ready), 32'(e.is_d));
        @(negedge clk);
        mem_ready = 1'b0;
        if (e.is_d && !keep_d) d_req = 1'b0;
        if (!e.is_d && !keep_i) i_req = 1'b0;
        #1;
        chk("bubble", 32'(mx_access), 32'd0);
        chk("no_ready_idle", 32'(mx_i_ready | mx_d_ready), 32'd0);
    endtask

    task automatic serve(input int lat, input bit keep_d, input bit keep_i);
        exp_t e;
        wait_grant(e);
        complete(e, lat, keep_d, keep_i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        exp_t e;
        resetn = 1'b0; i_req = 0; d_req = 0; d_wr = 0; flush = 0; mem_ready = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_size = 0; d_sel = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_access", 32'(mx_access), 32'd0);
        chk("rst_mem_a", mx_a, 32'd0);
        chk("rst_size_sel", {26'd0, mx_size, mx_sel}, 32'd0);
        chk("rst_starve", 32'(dut0.starve_cnt), 32'd0);

        // 1: lone instruction refill
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'hBFC0_0000; push_i();
        serve(3, 1'b0, 1'b0);

        // 2: simultaneous requests, data wins, I after the bubble
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'hBFC0_0040;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h1FAF_0000; d_sel = 4'h3; d_size = 2'b01;
        d_wdata = 32'hDEAD_BEEF;
        push_d(); push_i();
        serve(2, 1'b0, 1'b1);
        serve(2, 1'b0, 1'b0);

        // 3: starvation guard, I held while D keeps coming back
        do_reset();
        i_req = 1'b1; i_addr = 32'h0000_1000;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_2000; d_sel = 4'hF; d_size = 2'b10;
        d_wdata = 32'h0;
        repeat (4) push_d();
        push_i(); push_d();
        repeat (4) serve(1, 1'b1, 1'b0);
        chk("starve_at_limit", 32'(dut0.starve_cnt), 32'd4);
        serve(1, 1'b1, 1'b0);
        chk("starve_cleared", 32'(dut0.starve_cnt), 32'd0);
        serve(1, 1'b0, 1'b0);

        // 4: round-robin alternation after a lone I grant
        do_reset();
        sel_rr = 1'b1;
        i_req = 1'b1; i_addr = 32'h0000_3000; push_i();
        serve(1, 1'b0, 1'b1);
        d_req = 1'b1; d_addr = 32'h0000_4000;
        push_d(); push_i(); push_d(); push_i(); push_d();
        serve(1, 1'b1, 1'b1);
        serve(1, 1'b1, 1'b1);
        serve(1, 1'b1, 1'b1);
        serve(1, 1'b1, 1'b0);
        serve(1, 1'b0, 1'b0);
        sel_rr = 1'b0;

        // 5: flush behaviour
        do_reset();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_5000; d_sel = 4'h1; d_size = 2'b00;
        d_wdata = 32'h0000_00AB; push_d();
        wait_grant(e);
        flush = 1'b1; mem_ready = 1'b1;
        #1;
        chk("flush_d_ready", 32'(mx_d_ready), 32'd0);
        chk("flush_mem_flush", 32'(mx_flush), 32'd1);
        chk("flush_i_ready", 32'(mx_i_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0; mem_ready = 1'b0; d_req = 1'b0;
        #1;
        chk("flush_idle", 32'(mx_access), 32'd0);

        // flush in IDLE blocks D only
        flush = 1'b1; d_req = 1'b1;
        @(negedge clk);
        #1;
        chk("flush_blocks_d", 32'(mx_access), 32'd0);
        i_req = 1'b1; i_addr = 32'h0000_6000; push_i(); push_d();
        @(negedge clk);
        #1;
        chk("flush_i_granted", 32'(mx_access), 32'd1);
        wait_grant(e);
        // flush during BUSY_I: refill still completes
        mem_ready = 1'b1;
        #1;
        chk("flush_busy_i_ready", 32'(mx_i_ready), 32'd1);
        chk("flush_busy_i_mflush", 32'(mx_flush), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0; i_req = 1'b0; flush = 1'b0;
        serve(1, 1'b0, 1'b0);

        // 6: async reset mid-transaction
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_7000; push_i();
        wait_grant(e);
        mem_ready = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_access", 32'(mx_access), 32'd0);
        chk("arst_i_ready", 32'(mx_i_ready), 32'd0);
        chk("arst_mem_a", mx_a, 32'd0);
        @(negedge clk);
        mem_ready = 1'b0; i_req = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_idle", 32'(mx_access), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
